rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//   Owns the single write port (we3/a3/wd3) of the 32x32 register file. Shares it
//   round-robin between NREQ writeback sources (ALU, load unit, CSR/mul ...).
//   Keeps a per-register pending scoreboard so issue logic can detect RAW/WAW hazards.
//   Sits between the writeback sources and regfile; its we3/a3/wd3 drive regfile directly.
// PARAMETERS
//   NREQ  3   number of writeback requesters (2..8)
//   XLEN  32  data width
//   AW    5   register address width (2**AW registers)
// PORTS
//   clk          in   1          rising-edge clock
//   reset        in   1          asynchronous, active-high reset
//   req_valid    in   NREQ       requester i has a write pending
//   req_addr     in   NREQ*AW    destination reg; slice i = [i*AW +: AW]
//   req_data     in   NREQ*XLEN  write data; slice i = [i*XLEN +: XLEN]
//   req_ready    out  NREQ       one-hot grant; transfer = valid[i] & ready[i]
//   issue_valid  in   1          an instruction with destination issue_rd issues
//   issue_rd     in   AW         destination register of issuing instruction
//   issue_stall  out  1          issue_valid & pending[issue_rd] & issue_rd!=0
//   a1, a2       in   AW         source registers being read
//   hazard1/2    out  1          a1/a2 != 0 & pending[a1/a2]
//   we3          out  1          regfile write enable (registered)
//   a3           out  AW         regfile write address (registered)
//   wd3          out  XLEN       regfile write data (registered)
// BEHAVIOUR
//   Reset (async, immediate): we3=0, a3=0, wd3=0, pending[]=0, rr_ptr=0; req_ready=0.
//   Arbitration: combinational; scan from rr_ptr upward mod NREQ, first valid wins.
//     req_ready[i]=1 only for the winner; no valid -> req_ready=0. Ready depends on
//     valid; requesters must not make valid depend on ready. Requester holds
//     valid/addr/data stable until transfer.
//   rr_ptr: on a transfer from i, rr_ptr <= (i+1) mod NREQ; otherwise unchanged.
//   Output stage, 1-cycle latency: transfer at edge N -> cycle N+1: we3=1, a3=addr,
//     wd3=data; regfile commits at edge N+1. No transfer -> we3=0, a3/wd3 hold.
//     Back-to-back transfers give we3 high on consecutive cycles, no bubble.
//   Writes to x0: accepted (ready asserted, rr_ptr advances), but we3 stays 0 and
//     a3/wd3 hold.
//   Scoreboard pending[0..2**AW-1], pending[0] always 0:
//     set   at edge when issue_valid & !issue_stall & issue_rd!=0;
//     clear at edge when we3=1 & a3==r (the edge the regfile writes r).
//     Set and clear of the same reg on the same edge -> set wins (stays pending).
//     issue_stall=1 -> issue ignored; pending unchanged.
//   Hazards combinational from current pending; the reg being written this cycle still
//     reads hazard=1 (no bypass in this block).
//   Reset mid-operation: registered in-flight write discarded (we3 drops at once),
//     pending cleared, arbitration restarts at requester 0.
// TESTING
//   1 Assert reset with random inputs -> we3=0, a3=0, wd3=0, hazard1/2=0,
//     issue_stall=0, req_ready=0 immediately, without waiting for a clock.
//   2 req_valid=3'b010, addr1=5, data1=32'hDEADBEEF for one cycle -> req_ready=3'b010
//     same cycle; next cycle we3=1, a3=5, wd3=DEADBEEF; following cycle we3=0.
//   3 req_valid=3'b111 held, distinct addrs -> grants 0,1,2,0,1 on consecutive cycles;
//     we3 high continuously from the second cycle.
//   4 issue rd=7; a1=7 -> hazard1=1; requester 0 writes x7 -> hazard1 stays 1 through
//     the we3 cycle, 0 after; repeat with issue rd=7 on that write edge -> stays 1.
//   5 issue rd=7 while pending[7]=1 -> issue_stall=1, pending[7] unchanged; issue rd=0 ->
//     no stall, no pending; requester writes addr 0 -> accepted, we3 stays 0.
//   6 reset pulse between a transfer edge and its we3 cycle -> we3 never seen high,
//     pending cleared; after release req_valid=3'b110 grants requester 1 first.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin owner of the regfile write port with a per-register pending scoreboard
module rf_write_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_rd,
    output logic                 issue_stall,
    input  logic [AW-1:0]        a1,
    input  logic [AW-1:0]        a2,
    output logic                 hazard1,
    output logic                 hazard2,
    output logic                 we3,
    output logic [AW-1:0]        a3,
    output logic [XLEN-1:0]      wd3
);
    localparam int PW = $clog2(NREQ);
    localparam int NR = 2**AW;
    logic [PW-1:0]   rr_ptr, gidx;
    logic            gnt, wr;
    logic [AW-1:0]   gaddr;
    logic [XLEN-1:0] gdata;
    logic [NR-1:0]   pending, pend_nxt;
    always_comb begin
        int j;
        j = 0;
        req_ready = '0;
        gnt = 1'b0;
        gidx = '0;
        gaddr = '0;
        gdata = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) j -= NREQ;
            if (!gnt && req_valid[j]) begin
                gnt = 1'b1;
                gidx = PW'(j);
                gaddr = req_addr[j*AW +: AW];
                gdata = req_data[j*XLEN +: XLEN];
                req_ready[j] = !reset;
            end
        end
    end
    // x0 writes are consumed but never reach the regfile
    assign wr = gnt && (gaddr != '0);
    assign issue_stall = issue_valid && pending[issue_rd] && (issue_rd != '0);
    assign hazard1 = (a1 != '0) && pending[a1];
    assign hazard2 = (a2 != '0) && pending[a2];
    always_comb begin
        pend_nxt = pending;
        if (we3) pend_nxt[a3] = 1'b0;
        if (issue_valid && !issue_stall && issue_rd != '0) pend_nxt[issue_rd] = 1'b1;
        pend_nxt[0] = 1'b0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we3 <= 1'b0;
            a3 <= '0;
            wd3 <= '0;
            rr_ptr <= '0;
            pending <= '0;
        end else begin
            we3 <= wr;
            pending <= pend_nxt;
            if (wr) begin
                a3 <= gaddr;
                wd3 <= gdata;
            end
            if (gnt) rr_ptr <= (gidx == PW'(NREQ-1)) ? '0 : gidx + 1'b1;
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed stimulus with a write scoreboard checked by an independent monitor
module tb_rf_write_arbiter;
    logic        clk = 0, reset = 0;
    logic [2:0]  req_valid = '0;
    logic [14:0] req_addr = '0;
    logic [95:0] req_data = '0;
    logic [2:0]  req_ready;
    logic        issue_valid = 0, issue_stall;
    logic [4:0]  issue_rd = '0, a1 = '0, a2 = '0, a3;
    logic        hazard1, hazard2, we3;
    logic [31:0] wd3;
    logic [36:0] q[$];
    int pass_cnt = 0, total_cnt = 0;

    rf_write_arbiter #(.NREQ(3), .XLEN(32), .AW(5)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .issue_stall(issue_stall), .a1(a1), .a2(a2),
        .hazard1(hazard1), .hazard2(hazard2), .we3(we3), .a3(a3), .wd3(wd3)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!reset && we3 === 1'b1) begin
            if (q.size() == 0) check("unexpected_write", {27'd0, a3}, 32'hFFFF_FFFF);
            else begin
                logic [36:0] e;
                e = q.pop_front();
                check("wr_addr", {27'd0, a3}, {27'd0, e[36:32]});
                check("wr_data", wd3, e[31:0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset = 1;
        #2 reset = 0;
    endtask

    initial begin
        // Reset with random inputs, checked before any clock edge
        #2;
        req_valid = 3'($urandom);
        req_addr = 15'($urandom);
        req_data = {$urandom, $urandom, $urandom};
        issue_valid = 1;
        issue_rd = 5'($urandom_range(1, 31));
        a1 = 5'($urandom_range(1, 31));
        a2 = 5'($urandom_range(1, 31));
        reset = 1;
        #1;
        check("rst_we3", {31'd0, we3}, 0);
        check("rst_a3", {27'd0, a3}, 0);
        check("rst_wd3", wd3, 0);
        check("rst_haz1", {31'd0, hazard1}, 0);
        check("rst_haz2", {31'd0, hazard2}, 0);
        check("rst_stall", {31'd0, issue_stall}, 0);
        check("rst_ready", {29'd0, req_ready}, 0);
        step();
        step();
        req_valid = '0; req_addr = '0; req_data = '0;
        issue_valid = 0; issue_rd = '0; a1 = '0; a2 = '0;
        reset = 0;
        // Single write from requester 1
        step();
        req_valid = 3'b010; req_addr[5 +: 5] = 5'd5; req_data[32 +: 32] = 32'hDEADBEEF;
        q.push_back({5'd5, 32'hDEADBEEF});
        @(negedge clk);
        check("single_ready", {29'd0, req_ready}, 32'b010);
        step();
        req_valid = '0;
        step();
        @(negedge clk);
        check("single_we3_drop", {31'd0, we3}, 0);
        // Round robin with all requesters valid
        do_reset();
        req_valid = 3'b111;
        req_addr = {5'd3, 5'd2, 5'd1};
        req_data = {32'hC0, 32'hB0, 32'hA0};
        for (int i = 0; i < 5; i++) begin
            int g;
            g = i % 3;
            @(negedge clk);
            check("rr_ready", {29'd0, req_ready}, 32'(1 << g));
            if (i > 0) check("rr_we3_cont", {31'd0, we3}, 1);
            q.push_back({5'(g + 1), 32'hA0 + 32'(g * 16)});
        end
        step();
        req_valid = '0;
        // Scoreboard set/clear on x7
        issue_valid = 1; issue_rd = 5'd7; a1 = 5'd7;
        @(negedge clk);
        check("haz_before_set", {31'd0, hazard1}, 0);
        check("stall_first_issue", {31'd0, issue_stall}, 0);
        step();
        issue_valid = 0;
        @(negedge clk);
        check("haz_after_set", {31'd0, hazard1}, 1);
        step();
        req_valid = 3'b001; req_addr[0 +: 5] = 5'd7; req_data[0 +: 32] = 32'h77;
        q.push_back({5'd7, 32'h77});
        @(negedge clk);
        check("x7_ready", {29'd0, req_ready}, 32'b001);
        step();
        req_valid = '0;
        @(negedge clk);
        check("haz_during_we3", {31'd0, hazard1}, 1);
        step();
        @(negedge clk);
        check("haz_cleared", {31'd0, hazard1}, 0);
        step();
        req_valid = 3'b001; req_data[0 +: 32] = 32'h88;
        q.push_back({5'd7, 32'h88});
        @(negedge clk);
        check("x7b_ready", {29'd0, req_ready}, 32'b001);
        step();
        req_valid = '0; issue_valid = 1; issue_rd = 5'd7;
        @(negedge clk);
        check("stall_on_write_edge", {31'd0, issue_stall}, 0);
        step();
        issue_valid = 0;
        @(negedge clk);
        check("set_wins_clear", {31'd0, hazard1}, 1);
        // Stall, x0 issue and x0 write
        step();
        issue_valid = 1; issue_rd = 5'd7; a2 = 5'd7;
        @(negedge clk);
        check("stall_pending", {31'd0, issue_stall}, 1);
        check("haz2_pending", {31'd0, hazard2}, 1);
        step();
        issue_rd = 5'd0; a2 = 5'd0;
        @(negedge clk);
        check("stall_x0", {31'd0, issue_stall}, 0);
        check("haz2_x0", {31'd0, hazard2}, 0);
        step();
        issue_valid = 0;
        req_valid = 3'b100; req_addr[10 +: 5] = 5'd0; req_data[64 +: 32] = 32'h55;
        @(negedge clk);
        check("x0_ready", {29'd0, req_ready}, 32'b100);
        check("haz_kept", {31'd0, hazard1}, 1);
        step();
        req_valid = '0;
        @(negedge clk);
        check("x0_no_we3", {31'd0, we3}, 0);
        // Reset between transfer edge and its write cycle
        step();
        req_valid = 3'b010; req_addr[5 +: 5] = 5'd9; req_data[32 +: 32] = 32'h99;
        @(negedge clk);
        check("pre_rst_ready", {29'd0, req_ready}, 32'b010);
        step();
        reset = 1; req_valid = '0;
        #1;
        check("midrst_we3", {31'd0, we3}, 0);
        check("midrst_a3", {27'd0, a3}, 0);
        check("midrst_haz1", {31'd0, hazard1}, 0);
        step();
        reset = 0;
        req_valid = 3'b110;
        req_addr[5 +: 5] = 5'd10; req_data[32 +: 32] = 32'h1010;
        req_addr[10 +: 5] = 5'd11; req_data[64 +: 32] = 32'h2020;
        q.push_back({5'd10, 32'h1010});
        @(negedge clk);
        check("post_rst_ready", {29'd0, req_ready}, 32'b010);
        step();
        req_valid = '0;
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        step();
        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
